uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NREQ packet sources share one uart_tx byte transmitter.
// Packets are streamed byte by byte; a source can cut its packet short by dropping req.
module uart_tx_arb #(
    parameter int NREQ       = 4,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*8-1:0]     req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [LEN_W-1:0]      byte_idx,
    output logic [NREQ-1:0]       done,
    output logic                  aborted,
    output logic [7:0]            tx_data,
    output logic                  tx_data_vld,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] len;
    logic [7:0]       cur_byte;
    logic             cur_req;
    logic [7:0]       tx_data_q;
    logic             ready_prev;
    logic             force_done;
    logic             abort_q;
    logic [1:0]       stuck_cnt;
    logic [31:0]      gap_cnt;
    logic             strobe;
    logic             byte_done;
    logic             last_byte;

    // Priority distance from the slot after last_gnt; the smallest distance wins.
    always_comb begin
        int d;
        int best_d;
        win_found = 1'b0;
        win_idx   = '0;
        win_len   = '0;
        best_d    = NREQ;
        d         = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - 1 - int'(last_gnt)) % NREQ;
            if (req[i] && d < best_d) begin
                best_d    = d;
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        cur_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDX_W'(i)) begin
                cur_byte = req_data[i*8 +: 8];
                cur_req  = req[i];
            end
        end
    end

    assign strobe    = (state == LOAD) && tx_ready;
    // A byte is finished on a rising tx_ready, or at once when the transmitter never went busy.
    assign byte_done = (state == WAIT_DONE) && (force_done || (!ready_prev && tx_ready));
    assign last_byte = (byte_idx == len - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (|req) state_nxt = ARB;
            ARB: begin
                if (!win_found)           state_nxt = IDLE;
                else if (win_len == '0)   state_nxt = FIN;
                else                      state_nxt = LOAD;
            end
            LOAD:      if (tx_ready) state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready || stuck_cnt == 2'd3) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (byte_done) begin
                    if (last_byte || !cur_req) state_nxt = FIN;
                    else if (GAP_CYCLES > 0)   state_nxt = GAP;
                    else                       state_nxt = LOAD;
                end
            end
            GAP:       if (gap_cnt >= 32'(GAP_CYCLES - 1)) state_nxt = LOAD;
            FIN:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gidx       <= '0;
            last_gnt   <= IDX_W'(NREQ - 1);
            len        <= '0;
            byte_idx   <= '0;
            abort_q    <= 1'b0;
            tx_data_q  <= '0;
            ready_prev <= 1'b1;
            force_done <= 1'b0;
            stuck_cnt  <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            ready_prev <= tx_ready;
            case (state)
                ARB: begin
                    if (win_found) begin
                        gnt      <= NREQ'(1) << win_idx;
                        gidx     <= win_idx;
                        last_gnt <= win_idx;
                        len      <= win_len;
                        byte_idx <= '0;
                        abort_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (tx_ready) begin
                        tx_data_q  <= cur_byte;
                        stuck_cnt  <= '0;
                        force_done <= 1'b0;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_ready) begin
                        stuck_cnt <= stuck_cnt + 2'd1;
                        if (stuck_cnt == 2'd3) force_done <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (byte_done) begin
                        gap_cnt <= '0;
                        if (last_byte)     abort_q  <= 1'b0;
                        else if (!cur_req) abort_q  <= 1'b1;
                        else               byte_idx <= byte_idx + LEN_W'(1);
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 32'd1;
                FIN:     gnt     <= '0;
                default: ;
            endcase
        end
    end

    // The strobe cycle presents the live byte; afterwards the registered copy holds the line value.
    assign tx_data_vld = strobe;
    assign tx_data     = strobe ? cur_byte : tx_data_q;
    assign done        = (state == FIN) ? gnt : '0;
    assign aborted     = (state == FIN) && abort_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester and uart_tx models plus a round-robin packet reference model.
module tb_uart_tx_arb;
    localparam int NREQ  = 4;
    localparam int LEN_W = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*8-1:0]     req_data;
    logic [NREQ-1:0]       gnt, done;
    logic [LEN_W-1:0]      byte_idx;
    logic                  aborted, tx_data_vld, busy;
    logic [7:0]            tx_data;
    logic                  tx_ready = 1'b1;

    uart_tx_arb #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt), .byte_idx(byte_idx), .done(done), .aborted(aborted),
        .tx_data(tx_data), .tx_data_vld(tx_data_vld), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester configuration: packet count, lengths, data, optional drop index on the last packet.
    logic [7:0] mem [NREQ][4][256];
    int  pkt_len [NREQ][4];
    int  npkt    [NREQ];
    int  drop_at [NREQ];
    int  cur_pkt [NREQ];
    bit  dropped [NREQ];
    bit  go = 1'b0;
    bit  stuck = 1'b0;

    int  obs_s[$];
    int  obs_cyc[$];
    int  obs_d[$];
    int  exp_s[$];
    int  exp_d[$];
    int  max_idx = 0;
    int  cyc = 0;

    always_comb begin
        req_len  = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_pkt[i] < 4) begin
                req_len[i*LEN_W +: LEN_W] = LEN_W'(pkt_len[i][cur_pkt[i]]);
                req_data[i*8 +: 8]        = mem[i][cur_pkt[i]][byte_idx];
            end
        end
    end

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        onehot_idx = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) onehot_idx = i;
    endfunction

    // Monitor, requester behaviour and uart_tx model, all on the falling edge.
    initial begin
        int  g;
        int  pend;
        int  busy_left;
        bit  strobe_seen;
        logic [7:0] last_tx;
        pend = -1; busy_left = 0; last_tx = '0;
        for (int i = 0; i < NREQ; i++) begin cur_pkt[i] = 0; dropped[i] = 1'b0; end
        forever begin
            @(negedge clk);
            cyc++;
            strobe_seen = 1'b0;
            if (rst) begin
                for (int i = 0; i < NREQ; i++) begin cur_pkt[i] = 0; dropped[i] = 1'b0; end
                pend = -1; busy_left = 0; last_tx = '0; tx_ready = 1'b1;
            end else begin
                n_cmp++;
                if (!$onehot0(gnt)) begin n_bad++; $display("FAIL gnt_onehot got %b want at most one bit", gnt); end
                if (tx_data_vld) begin
                    n_cmp++;
                    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL vld_while_busy got tx_ready=%b want 1", tx_ready); end
                    g = onehot_idx(gnt);
                    obs_s.push_back(g * 256 + int'(tx_data));
                    obs_cyc.push_back(cyc);
                    if (int'(byte_idx) > max_idx) max_idx = int'(byte_idx);
                    last_tx = tx_data;
                    strobe_seen = 1'b1;
                    if (g >= 0 && cur_pkt[g] == npkt[g] - 1 && drop_at[g] == int'(byte_idx)) dropped[g] = 1'b1;
                end else begin
                    n_cmp++;
                    if (tx_data !== last_tx) begin n_bad++; $display("FAIL tx_data_hold got %h want %h", tx_data, last_tx); end
                end
                if (|done) begin
                    g = onehot_idx(done);
                    obs_d.push_back(g * 2 + int'(aborted));
                    if (g >= 0) cur_pkt[g]++;
                end
                if (stuck) begin
                    tx_ready = 1'b1; pend = -1; busy_left = 0;
                end else begin
                    if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) tx_ready = 1'b1;
                    end else if (pend >= 0) begin
                        if (pend == 0) begin tx_ready = 1'b0; busy_left = $urandom_range(2, 6); pend = -1; end
                        else pend--;
                    end
                    if (strobe_seen) pend = $urandom_range(0, 2);
                end
            end
            for (int i = 0; i < NREQ; i++) req[i] = go && (cur_pkt[i] < npkt[i]) && !dropped[i];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        go = 1'b0; stuck = 1'b0; rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin npkt[i] = 0; drop_at[i] = -1; end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_s.delete(); obs_cyc.delete(); obs_d.delete(); exp_s.delete(); exp_d.delete();
        max_idx = 0;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (obs_d.size() < n && c < budget) begin @(negedge clk); c++; end
        ok = (obs_d.size() >= n);
        repeat (30) @(negedge clk);
    endtask

    // Reference: all requests raised together after reset, so service follows a rotating pointer.
    task automatic build_expected();
        int rem[NREQ];
        int pk[NREQ];
        int p, w, c, nb, ab, L;
        exp_s.delete(); exp_d.delete();
        for (int i = 0; i < NREQ; i++) begin rem[i] = npkt[i]; pk[i] = 0; end
        p = 0;
        forever begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (p + k) % NREQ;
                if (w < 0 && rem[c] > 0) w = c;
            end
            if (w < 0) break;
            L = pkt_len[w][pk[w]]; nb = L; ab = 0;
            if (rem[w] == 1 && drop_at[w] >= 0 && drop_at[w] < L) begin
                nb = drop_at[w] + 1;
                ab = (drop_at[w] < L - 1) ? 1 : 0;
            end
            for (int b = 0; b < nb; b++) exp_s.push_back(w * 256 + int'(mem[w][pk[w]][b]));
            exp_d.push_back(w * 2 + ab);
            pk[w]++; rem[w]--; p = (w + 1) % NREQ;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, done, aborted, tx_data, tx_data_vld, byte_idx, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got gnt=%b done=%b ab=%b txd=%h vld=%b idx=%0d busy=%b want all zero",
                     gnt, done, aborted, tx_data, tx_data_vld, byte_idx, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        npkt[0] = 1; pkt_len[0][0] = 3;
        mem[0][0][0] = 8'h48; mem[0][0][1] = 8'h49; mem[0][0][2] = 8'h21;
        exp_s = '{'h48, 'h49, 'h21};
        exp_d = '{0};
        go = 1'b1;
        wait_dones(1, 500, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout got %0d dones want 1", obs_d.size()); end
        n_cmp++; if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL single_nstrobe got %0d want %0d", obs_s.size(), exp_s.size()); end
        foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL single_byte%0d got %0h want %0h", k, obs_s[k], exp_s[k]); end end
        n_cmp++; if (obs_d.size() != 1 || obs_d[0] != exp_d[0]) begin n_bad++; $display("FAIL single_done got n=%0d first=%0d want n=1 code=%0d", obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : -1, exp_d[0]); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) if (i != 2) begin
            npkt[i] = 2;
            for (int p = 0; p < 2; p++) begin pkt_len[i][p] = 1; mem[i][p][0] = 8'(8'hA0 + i * 16 + p); end
        end
        exp_d = '{0, 2, 6, 0, 2, 6};
        go = 1'b1;
        wait_dones(6, 1000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout got %0d dones want 6", obs_d.size()); end
        n_cmp++; if (obs_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rr_ndone got %0d want %0d", obs_d.size(), exp_d.size()); end
        foreach (exp_d[k]) if (k < obs_d.size()) begin n_cmp++; if (obs_d[k] != exp_d[k]) begin n_bad++; $display("FAIL rr_order%0d got req %0d ab %0d want req %0d", k, obs_d[k] / 2, obs_d[k] % 2, exp_d[k] / 2); end end
        n_cmp++; if (obs_s.size() != 6) begin n_bad++; $display("FAIL rr_nstrobe got %0d want 6", obs_s.size()); end
    endtask

    task automatic test_zero_len();
        int c;
        bit seen;
        do_reset();
        npkt[2] = 1; pkt_len[2][0] = 0;
        go = 1'b1;
        c = 0;
        while (req[2] !== 1'b1 && c < 5) begin @(negedge clk); c++; end
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(negedge clk);
            if (|done) begin
                seen = 1'b1;
                n_cmp++; if (done !== 4'b0100 || aborted !== 1'b0) begin n_bad++; $display("FAIL zero_done got done=%b ab=%b want 0100/0", done, aborted); end
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL zero_latency got no done want done within 3 cycles"); end
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_s.size() != 0) begin n_bad++; $display("FAIL zero_nstrobe got %0d want 0", obs_s.size()); end
        n_cmp++; if (obs_d.size() != 1) begin n_bad++; $display("FAIL zero_ndone got %0d want 1", obs_d.size()); end
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        npkt[1] = 1; pkt_len[1][0] = 5; drop_at[1] = 2;
        for (int b = 0; b < 5; b++) mem[1][0][b] = 8'(8'h10 + b);
        exp_s = '{256 + 'h10, 256 + 'h11, 256 + 'h12};
        exp_d = '{3};
        go = 1'b1;
        wait_dones(1, 500, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_timeout got %0d dones want 1", obs_d.size()); end
        n_cmp++; if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL abort_nstrobe got %0d want %0d", obs_s.size(), exp_s.size()); end
        foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL abort_byte%0d got %0h want %0h", k, obs_s[k], exp_s[k]); end end
        n_cmp++; if (obs_d.size() != 1 || obs_d[0] != 3) begin n_bad++; $display("FAIL abort_done got n=%0d first=%0d want n=1 code=3", obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : -1); end
    endtask

    task automatic test_stuck_ready();
        bit ok;
        int gap;
        do_reset();
        stuck = 1'b1;
        npkt[0] = 1; pkt_len[0][0] = 2;
        mem[0][0][0] = 8'h5A; mem[0][0][1] = 8'hA5;
        exp_s = '{'h5A, 'hA5};
        go = 1'b1;
        wait_dones(1, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck_timeout got %0d dones want 1", obs_d.size()); end
        n_cmp++; if (obs_s.size() != 2) begin n_bad++; $display("FAIL stuck_nstrobe got %0d want 2", obs_s.size()); end
        foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL stuck_byte%0d got %0h want %0h", k, obs_s[k], exp_s[k]); end end
        if (obs_cyc.size() >= 2) begin
            gap = obs_cyc[1] - obs_cyc[0];
            n_cmp++; if (gap < 5 || gap > 7) begin n_bad++; $display("FAIL stuck_spacing got %0d cycles want 5..7", gap); end
        end
        n_cmp++; if (obs_d.size() != 1 || obs_d[0] != 0) begin n_bad++; $display("FAIL stuck_done got n=%0d want one done[0] ab=0", obs_d.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c;
        do_reset();
        npkt[0] = 1; pkt_len[0][0] = 3;
        mem[0][0][0] = 8'h31; mem[0][0][1] = 8'h32; mem[0][0][2] = 8'h33;
        go = 1'b1;
        c = 0;
        while (obs_s.size() < 2 && c < 300) begin @(negedge clk); c++; end
        c = 0;
        while (tx_ready !== 1'b0 && c < 10) begin @(negedge clk); c++; end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_byte1_busy got tx_ready=%b want 0", tx_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, done, aborted, tx_data, tx_data_vld, byte_idx, busy} !== '0) begin
            n_bad++;
            $display("FAIL rmid_outputs got gnt=%b done=%b txd=%h idx=%0d busy=%b want all zero", gnt, done, tx_data, byte_idx, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (obs_d.size() != 0) begin n_bad++; $display("FAIL rmid_nodone got %0d dones want 0", obs_d.size()); end
        obs_s.delete(); obs_cyc.delete();
        exp_s = '{'h31, 'h32, 'h33};
        wait_dones(1, 500, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout got %0d dones want 1", obs_d.size()); end
        n_cmp++; if (obs_s.size() != 3) begin n_bad++; $display("FAIL rmid_nstrobe got %0d want 3", obs_s.size()); end
        foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL rmid_byte%0d got %0h want %0h", k, obs_s[k], exp_s[k]); end end
    endtask

    task automatic test_max_len();
        bit ok;
        do_reset();
        npkt[3] = 1; pkt_len[3][0] = 255;
        for (int b = 0; b < 256; b++) mem[3][0][b] = 8'($urandom);
        build_expected();
        go = 1'b1;
        wait_dones(1, 6000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL maxlen_timeout got %0d dones want 1", obs_d.size()); end
        n_cmp++; if (obs_s.size() != 255) begin n_bad++; $display("FAIL maxlen_nstrobe got %0d want 255", obs_s.size()); end
        foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL maxlen_byte%0d got %0h want %0h", k, obs_s[k], exp_s[k]); end end
        n_cmp++; if (max_idx != 254) begin n_bad++; $display("FAIL maxlen_last_idx got %0d want 254", max_idx); end
        n_cmp++; if (obs_d.size() != 1 || obs_d[0] != 6) begin n_bad++; $display("FAIL maxlen_done got n=%0d want one done[3] ab=0", obs_d.size()); end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            stuck = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NREQ; i++) begin
                npkt[i] = $urandom_range(0, 3);
                for (int p = 0; p < 4; p++) begin
                    pkt_len[i][p] = $urandom_range(0, 5);
                    for (int b = 0; b < 8; b++) mem[i][p][b] = 8'($urandom);
                end
                if (npkt[i] > 0 && pkt_len[i][npkt[i] - 1] > 0 && $urandom_range(0, 2) == 0)
                    drop_at[i] = $urandom_range(0, pkt_len[i][npkt[i] - 1] - 1);
            end
            build_expected();
            go = 1'b1;
            wait_dones(exp_d.size(), 3000, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout got %0d dones want %0d", it, obs_d.size(), exp_d.size()); end
            n_cmp++; if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL rand%0d_nstrobe got %0d want %0d", it, obs_s.size(), exp_s.size()); end
            foreach (exp_s[k]) if (k < obs_s.size()) begin n_cmp++; if (obs_s[k] != exp_s[k]) begin n_bad++; $display("FAIL rand%0d_strobe%0d got %0h want %0h", it, k, obs_s[k], exp_s[k]); end end
            n_cmp++; if (obs_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rand%0d_ndone got %0d want %0d", it, obs_d.size(), exp_d.size()); end
            foreach (exp_d[k]) if (k < obs_d.size()) begin n_cmp++; if (obs_d[k] != exp_d[k]) begin n_bad++; $display("FAIL rand%0d_done%0d got %0d want %0d", it, k, obs_d[k], exp_d[k]); end end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rand%0d_idle got busy=%b want 0", it, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_stuck_ready();
        test_reset_mid();
        test_max_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
